matvec_reader: RTL
==================

MATVEC_READER -- requirements
Module: matvec_reader

Interface
REQ-001 Parameter R, default 8: rows of the attached matvec_mul, i.e. elements per result vector.
REQ-002 Parameter C, default 8: columns of the attached matvec_mul.
REQ-003 Parameters W_X and W_K, default 8 each: operand widths of the attached matvec_mul.
REQ-004 Derived W_Y = W_X + W_K + clog2(C) (19 at defaults) and LAT = clog2(C) + 1 (4 at defaults) SHALL be local, not overridable.
REQ-005 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock shared with matvec_mul.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 s_valid  input  1  upstream k/x operands presented to matvec_mul this cycle are a real vector.
REQ-009 s_ready  output  1  operands are consumed this cycle; equals cen.
REQ-010 cen  output  1  clock enable driven to matvec_mul.
REQ-011 y  input  R x W_Y signed  result bus from matvec_mul.
REQ-012 m_valid  output  1  serial result element valid.
REQ-013 m_ready  input  1  downstream accepts element.
REQ-014 m_data  output  W_Y signed  current result element.
REQ-015 m_last  output  1  m_data is element R-1 of its vector.

Function
REQ-016 Block SHALL keep a LAT-bit valid shift register vld; when cen=1, vld[0] <= s_valid and vld[i] <= vld[i-1]; when cen=0, vld holds.
REQ-017 tail = vld[LAT-1]; tail=1 SHALL mean y carries a complete result for the vector sampled LAT enabled edges earlier.
REQ-018 Block SHALL hold one R x W_Y output buffer, an element index idx (0..R-1), and FSM states IDLE (buffer empty) and SEND (buffer full).
REQ-019 last_acc = (state==SEND && m_ready && idx==R-1).
REQ-020 capture = tail && (state==IDLE || last_acc); on capture, buffer <= y, idx <= 0, state <= SEND.
REQ-021 cen SHALL be 0 while rst=1, else (!tail || capture); a frozen pipeline keeps y and vld stable until capture.
REQ-022 m_valid SHALL equal (state==SEND); m_data = buffer[idx]; m_last = m_valid && idx==R-1.
REQ-023 Elements SHALL be emitted in row order 0..R-1.
REQ-024 On m_valid && m_ready with idx<R-1, idx SHALL increment.
REQ-025 On last_acc without capture, state SHALL go to IDLE; with capture, state SHALL stay SEND with idx=0 and no bubble cycle.
REQ-026 m_data and m_last SHALL be stable while m_valid && !m_ready.
REQ-027 Invalid bubbles (vld=0) reaching tail SHALL never be captured and SHALL never stall cen.
REQ-028 Sustained throughput SHALL be one vector per R cycles with m_ready=1; no vector SHALL be dropped or duplicated under any m_ready pattern.

Reset
REQ-029 With rst=1, the next edge SHALL clear vld, set state IDLE, idx 0, m_valid 0, m_last 0; buffer contents SHALL be don't-care.
REQ-030 Reset mid-serialization or mid-pipeline SHALL discard all in-flight vectors; the uncleared matvec_mul tree SHALL be masked by vld.

Verification
REQ-031 Reset, then 10 cycles with s_valid=0 and y at arbitrary values -> m_valid stays 0 and cen stays 1 throughout.
REQ-032 One s_valid pulse with all k=1 and all x=2, m_ready=1 -> m_valid rises 4 enabled cycles later; 8 beats of value 16; m_last on beat 8 only.
REQ-033 Three back-to-back vectors with distinct values and m_ready=0 for 20 cycles, then 1 -> cen drops when the 2nd vector reaches tail; 24 beats follow in order with no loss.
REQ-034 Two vectors spaced 8 cycles apart with m_ready=1 -> 16 contiguous beats; the capture coincides with last_acc and m_valid has no gap.
REQ-035 m_ready toggled pseudo-randomly -> m_data and m_last stay stable on each stalled cycle; the scoreboard matches the reference matrix-vector product.
REQ-036 rst asserted during beat 3 of a vector with one more vector in flight -> m_valid=0 on the next cycle; neither vector is emitted afterwards.

Source files
------------

// File: rtl/matvec_reader.sv
// matvec_reader: tracks valid vectors through the matvec_mul pipeline,
// captures each finished result vector into a buffer and streams it out
// one element per handshake. The multiplier is stalled through cen only
// when a valid result reaches the pipeline tail and the buffer is still busy.
module matvec_reader #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int W_Y = W_X + W_K + $clog2(C),
    localparam int LAT = $clog2(C) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        cen,
    input  logic signed [R-1:0][W_Y-1:0] y,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [W_Y-1:0]       m_data,
    output logic                        m_last
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(R - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [LAT-1:0]         vld_q, vld_d;
    logic [R-1:0][W_Y-1:0]  buf_q, buf_d;

    logic tail;
    logic last_acc;
    logic capture;

    // Pipeline valid tracking, capture decision and multiplier clock enable
    always_comb begin
        tail     = vld_q[LAT-1];
        last_acc = (state_q == SEND) && m_ready && (idx_q == IDX_LAST);
        capture  = tail && ((state_q == IDLE) || last_acc);
        // Only a valid tail that cannot be captured freezes the pipeline;
        // bubbles at the tail simply fall off.
        cen      = !rst && (!tail || capture);
        s_ready  = cen;
        vld_d    = vld_q;
        if (cen) begin
            vld_d[0] = s_valid;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Output FSM: capture on empty buffer or on the final accepted element
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (capture) begin
            // Reloading on last_acc keeps SEND asserted with no bubble cycle.
            buf_d   = y;
            idx_d   = '0;
            state_d = SEND;
        end else if ((state_q == SEND) && m_ready) begin
            if (idx_q == IDX_LAST) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Serial output view of the buffer
    always_comb begin
        m_valid = (state_q == SEND);
        m_data  = buf_q[idx_q];
        m_last  = m_valid && (idx_q == IDX_LAST);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Result buffer; contents are meaningless until the first capture
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule
